// File: rtl/adc_sample_capture_if.sv
// Host-side control, status and buffer read port of adc_sample_capture.
// The master modport is the host and the slave modport is the capture block.
interface adc_sample_capture_if #(
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_READS_BITS = 16,
  parameter int ADDR_WIDTH     = 10
);
  logic                      start;
  logic                      abort;
  logic                      trig_mode;
  logic [DATA_WIDTH-1:0]     threshold;
  logic [NUM_READS_BITS-1:0] num_reads;
  logic                      busy;
  logic                      done;
  logic [NUM_READS_BITS-1:0] samples_stored;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0]     rd_data;

  modport master (
    output start, abort, trig_mode, threshold, num_reads, rd_addr,
    input  busy, done, samples_stored, rd_data
  );

  modport slave (
    input  start, abort, trig_mode, threshold, num_reads, rd_addr,
    output busy, done, samples_stored, rd_data
  );
endinterface

// File: rtl/adc_sample_capture.sv
// Moves deserialized ADC words from the dco domain into clk, captures a programmed
// number of them (optionally after a rising threshold crossing) into a readable buffer.
module adc_sample_capture #(
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_READS_BITS = 16,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dco,
  input  logic [DATA_WIDTH-1:0] des_data,
  input  logic                  read_complete,
  adc_sample_capture_if.slave   host
);
  localparam int NW    = NUM_READS_BITS + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

  // dco domain: hold the word and flip a toggle to announce it
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_tgl;

  always_ff @(posedge dco or negedge rstn) begin
    if (!rstn) begin
      hold_reg <= '0;
      hold_tgl <= 1'b0;
    end else if (read_complete) begin
      hold_reg <= des_data;
      hold_tgl <= ~hold_tgl;
    end
  end

  // [0],[1] synchronize, [2] is the edge-detect history
  logic [2:0] tgl_pipe;
  logic       sample_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tgl_pipe <= '0;
    else       tgl_pipe <= {tgl_pipe[1:0], hold_tgl};
  end

  // hold_reg is quiet for several clk cycles around each toggle, so it is read directly
  assign sample_vld = tgl_pipe[2] ^ tgl_pipe[1];

  state_t                    state, nxt;
  logic [NW-1:0]             n_lat;
  logic [NW-1:0]             n_req;
  logic [NW-1:0]             cnt_inc;
  logic [NUM_READS_BITS-1:0] stored;
  logic [DATA_WIDTH-1:0]     prev;
  logic                      prev_valid;
  logic                      done_r;
  logic                      fire;
  logic                      last;
  logic                      load;
  logic                      wr_en;
  logic                      busy_c;

  assign n_req   = ({1'b0, host.num_reads} > DEPTH_N) ? DEPTH_N : {1'b0, host.num_reads};
  assign cnt_inc = {1'b0, stored} + NW'(1);
  assign last    = (cnt_inc == n_lat);
  assign fire    = prev_valid && (prev < host.threshold) && (hold_reg >= host.threshold);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (host.start && (n_req != '0))
          nxt = host.trig_mode ? S_ARMED : S_CAPTURE;
      end
      S_ARMED: begin
        if (host.abort)              nxt = S_IDLE;
        else if (sample_vld && fire) nxt = last ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (host.abort)              nxt = S_IDLE;
        else if (sample_vld && last) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    wr_en  = 1'b0;
    load   = 1'b0;
    case (state)
      S_IDLE:    load = host.start;
      S_ARMED: begin
        busy_c = 1'b1;
        wr_en  = !host.abort && sample_vld && fire;
      end
      S_CAPTURE: begin
        busy_c = 1'b1;
        wr_en  = !host.abort && sample_vld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_lat      <= '0;
      stored     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      done_r     <= 1'b0;
    end else if (load) begin
      n_lat      <= n_req;
      stored     <= '0;
      prev_valid <= 1'b0;
      done_r     <= (n_req == '0);
    end else begin
      done_r <= wr_en && last;
      if (wr_en) stored <= stored + NUM_READS_BITS'(1);
      // a non-firing sample in ARMED becomes the reference for the next one
      if (state == S_ARMED && sample_vld && !host.abort && !fire) begin
        prev       <= hold_reg;
        prev_valid <= 1'b1;
      end
    end
  end

  // Buffer is not reset; stored never exceeds DEPTH so the address never wraps
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[stored[ADDR_WIDTH-1:0]] <= hold_reg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_q <= '0;
    else       rd_q <= mem[host.rd_addr];
  end

  assign host.busy           = busy_c;
  assign host.done           = done_r;
  assign host.samples_stored = stored;
  assign host.rd_data        = rd_q;
endmodule

// File: tb/tb_adc_sample_capture.sv
// Self-checking bench for adc_sample_capture: directed cases plus randomized
// captures over a swept clk/dco ratio, checked against a word-list reference model.
`timescale 1ns/1ps
module tb_adc_sample_capture;
  localparam int DW  = 12;
  localparam int NRB = 16;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          dco = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] des_data = '0;
  logic          read_complete = 1'b0;
  real           dco_half = 5.0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit busy_seen = 0;
  int exp_q[$];

  adc_sample_capture_if #(.DATA_WIDTH(DW), .NUM_READS_BITS(NRB), .ADDR_WIDTH(AW)) hif();

  adc_sample_capture #(.DATA_WIDTH(DW), .NUM_READS_BITS(NRB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .dco(dco), .des_data(des_data),
    .read_complete(read_complete), .host(hif)
  );

  always #5 clk = ~clk;
  initial begin
    #1.3;
    forever #(dco_half) dco = ~dco;
  end

  always @(negedge clk) begin
    if (hif.done) done_cnt++;
    if (hif.busy) busy_seen = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the word list applying the arm/trigger/count rules directly
  function automatic void model(input int words[$], input bit trig, input int th, input int n);
    bit armed = trig;
    bit pv = 0;
    int prev = 0;
    exp_q.delete();
    foreach (words[i]) begin
      if (exp_q.size() >= n) break;
      if (armed) begin
        if (pv && prev < th && words[i] >= th) begin
          armed = 0;
          exp_q.push_back(words[i]);
        end else begin
          prev = words[i];
          pv = 1;
        end
      end else begin
        exp_q.push_back(words[i]);
      end
    end
  endfunction

  task automatic send_word(input int w);
    @(negedge dco);
    des_data = DW'(w);
    read_complete = 1'b1;
    @(negedge dco);
    read_complete = 1'b0;
    repeat (5) @(negedge dco);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_start(input int num, input bit trig, input int th);
    @(negedge clk);
    hif.num_reads = NRB'(num);
    hif.trig_mode = trig;
    hif.threshold = DW'(th);
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    hif.abort = 1'b1;
    @(negedge clk);
    hif.abort = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    @(negedge clk);
    hif.rd_addr = AW'(a);
    @(negedge clk);
    chk(tag, hif.rd_data, exp);
  endtask

  // Full capture: start, feed words, compare status and buffer with the model.
  // An unfinished capture is expected to still be busy and is then aborted.
  task automatic run_capture(input string tag, input bit trig, input int th,
                             input int num, input int words[$]);
    int  n;
    bit  exp_done;
    n = (num > (1 << AW)) ? (1 << AW) : num;
    done_cnt = 0;
    pulse_start(num, trig, th);
    foreach (words[i]) send_word(words[i]);
    settle();
    model(words, trig, th, n);
    exp_done = (exp_q.size() == n);
    chk({tag, ".done"}, done_cnt, exp_done ? 1 : 0);
    chk({tag, ".busy"}, hif.busy, exp_done ? 0 : 1);
    chk({tag, ".stored"}, hif.samples_stored, exp_q.size());
    if (!exp_done) begin
      pulse_abort();
      settle();
      chk({tag, ".abort_busy"}, hif.busy, 0);
      chk({tag, ".abort_done"}, done_cnt, 0);
      chk({tag, ".abort_stored"}, hif.samples_stored, exp_q.size());
    end
    foreach (exp_q[i]) rd_chk($sformatf("%s.mem%0d", tag, i), i, exp_q[i]);
  endtask

  initial begin
    int w[$];
    int n, nw, th;
    bit trig;

    hif.start = 0; hif.abort = 0; hif.trig_mode = 0;
    hif.threshold = '0; hif.num_reads = '0; hif.rd_addr = '0;

    repeat (3) @(negedge clk);
    chk("rst.busy", hif.busy, 0);
    chk("rst.done", hif.done, 0);
    chk("rst.stored", hif.samples_stored, 0);
    chk("rst.rd_data", hif.rd_data, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    w = '{32'h001, 32'h002, 32'h003, 32'h004};
    run_capture("imm4", 0, 0, 4, w);

    w = '{32'h100, 32'h7FF, 32'h800, 32'h900};
    run_capture("trig", 1, 32'h800, 2, w);

    w = '{32'hFFF, 32'hFFF, 32'hFFF, 32'hFFF, 32'hFFF};
    run_capture("notrig", 1, 32'h800, 3, w);

    // zero-length request: done the cycle after start, never busy
    done_cnt = 0;
    busy_seen = 0;
    pulse_start(0, 0, 0);
    chk("n0.done_pulse", hif.done, 1);
    @(negedge clk);
    chk("n0.done_low", hif.done, 0);
    settle();
    chk("n0.done_cnt", done_cnt, 1);
    chk("n0.busy_seen", busy_seen, 0);

    // oversize request clamps to buffer depth
    w.delete();
    for (int i = 0; i < 1030; i++) w.push_back((i * 7 + 3) & 32'hFFF);
    run_capture("clamp", 0, 0, 32'hFFFF, w);

    // reset in the middle of a capture
    done_cnt = 0;
    pulse_start(10, 0, 0);
    for (int i = 0; i < 5; i++) send_word(32'h0A0 + i);
    settle();
    chk("rstmid.stored_before", hif.samples_stored, 5);
    chk("rstmid.busy_before", hif.busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid.busy", hif.busy, 0);
    chk("rstmid.stored", hif.samples_stored, 0);
    chk("rstmid.rd_data", hif.rd_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    settle();
    chk("rstmid.no_done", done_cnt, 0);
    w = '{32'h3A5, 32'h5A3, 32'h0F0};
    run_capture("after_rst", 0, 0, 3, w);

    // randomized captures over a swept clk/dco ratio
    for (int it = 0; it < 24; it++) begin
      dco_half = 5.0 * (1.0 + $urandom_range(0, 27) / 10.0);
      trig = 1'($urandom_range(0, 1));
      th   = $urandom_range(32'h100, 32'hEFF);
      n    = $urandom_range(5, 40);
      nw   = $urandom_range(n / 2, n + 20);
      w.delete();
      for (int i = 0; i < nw; i++) w.push_back($urandom_range(0, 32'hFFF));
      run_capture($sformatf("rnd%0d", it), trig, th, n, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
